// File: rtl/simon64_96_pkg.sv
// Shared SIMON64/96 key-schedule constants, z2 sequence and FSM state type.
// Imported by the key-expansion top and the per-round key-step sub-module.
package simon64_96_pkg;

    localparam int ROUNDS    = 42;
    localparam int WORD      = 32;
    localparam int KEY_WORDS = 3;

    // Leftmost character is z2[0]; z2_bit() flips the indexing accordingly.
    localparam logic [61:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    localparam logic [31:0] C_CONST = 32'hFFFFFFFC;

    typedef enum logic {
        S_IDLE,
        S_EXPAND
    } ks_state_t;

    function automatic logic z2_bit(input logic [5:0] idx);
        logic [5:0] pos;
        pos = 6'd61 - idx;
        return Z2[pos];
    endfunction

endpackage

// File: rtl/simon64_96_key_step.sv
// One SIMON64/96 key-schedule step: new = ~w0 ^ 3 ^ z ^ tmp, tmp = ROR3(w2) ^ ROR4(w2).
// Purely combinational so the round datapath bench can reuse it as a golden model.
module simon64_96_key_step
    import simon64_96_pkg::*;
(
    input  logic [WORD-1:0] i_w0,
    input  logic [WORD-1:0] i_w2,
    input  logic            i_z,
    output logic [WORD-1:0] o_key
);

    logic [WORD-1:0] w_r3;
    logic [WORD-1:0] w_tmp;

    assign w_r3  = {i_w2[2:0], i_w2[WORD-1:3]};
    assign w_tmp = w_r3 ^ {w_r3[0], w_r3[WORD-1:1]};

    // ~w0 ^ 3 folds into a single XOR with C_CONST.
    assign o_key = i_w0 ^ C_CONST ^ {{(WORD-1){1'b0}}, i_z} ^ w_tmp;

endmodule

// File: rtl/simon64_96_key_expand.sv
// SIMON64/96 key expansion: captures a 96-bit key, writes 42 round keys one per clock.
// Optional SIMON_KEYSCHED_REVERSE_EN adds rdReverse to read the buffer in decrypt order.
module simon64_96_key_expand
    import simon64_96_pkg::*;
#(
    parameter int ROUNDS = 42,
    parameter int WORD   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [95:0]       keyIn,
    output logic              busy,
    output logic              done,
    output logic              keyValid,
    input  logic [5:0]        rdAddr,
`ifdef SIMON_KEYSCHED_REVERSE_EN
    input  logic              rdReverse,
`endif
    output logic [WORD-1:0]   rdKey
);

    ks_state_t       r_state;
    ks_state_t       w_next_state;
    logic [5:0]      r_i;
    logic [WORD-1:0] r_w0;
    logic [WORD-1:0] r_w1;
    logic [WORD-1:0] r_w2;
    logic [WORD-1:0] r_buf [ROUNDS];
    logic            r_done;
    logic            r_valid;

    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic [WORD-1:0] w_new;
    logic [5:0]      w_idx;

    simon64_96_key_step u_step (
        .i_w0  (r_w0),
        .i_w2  (r_w2),
        .i_z   (z2_bit(r_i - 6'(KEY_WORDS))),
        .o_key (w_new)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_step = 1'b1;
                if (r_i == 6'(ROUNDS - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            for (int k = 0; k < ROUNDS; k++) r_buf[k] <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            if (w_load) begin
                r_w0     <= keyIn[31:0];
                r_w1     <= keyIn[63:32];
                r_w2     <= keyIn[95:64];
                r_buf[0] <= keyIn[31:0];
                r_buf[1] <= keyIn[63:32];
                r_buf[2] <= keyIn[95:64];
                r_i      <= 6'(KEY_WORDS);
                r_valid  <= 1'b0;
            end
            if (w_step) begin
                r_buf[r_i] <= w_new;
                r_w0       <= r_w1;
                r_w1       <= r_w2;
                r_w2       <= w_new;
                r_i        <= r_i + 6'd1;
            end
            if (w_last) begin
                r_done  <= 1'b1;
                r_valid <= 1'b1;
            end
        end
    end

`ifdef SIMON_KEYSCHED_REVERSE_EN
    assign w_idx = rdReverse ? (6'(ROUNDS - 1) - rdAddr) : rdAddr;
`else
    assign w_idx = rdAddr;
`endif

    // Out-of-range addresses read as zero rather than aliasing a live entry.
    assign rdKey    = (rdAddr < 6'(ROUNDS)) ? r_buf[w_idx] : '0;
    assign busy     = (r_state == S_EXPAND);
    assign done     = r_done;
    assign keyValid = r_valid;

endmodule

// File: tb/tb_simon64_96_key_expand.sv
// Directed bench for simon64_96_key_expand: schedule spot values, timing, abort/ignore cases,
// and full encrypt/decrypt of the reference vector through a bench-side round function.
module tb_simon64_96_key_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [95:0] keyIn;
    logic        busy;
    logic        done;
    logic        keyValid;
    logic [5:0]  rdAddr;
    logic [31:0] rdKey;
`ifdef SIMON_KEYSCHED_REVERSE_EN
    logic        rdReverse;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [95:0] K1 = 96'h131211100b0a090803020100;
    localparam logic [95:0] K2 = 96'hdeadbeef0123456789abcdef;
    localparam logic [63:0] PT = 64'h6f7220676e696c63;
    localparam logic [63:0] CT = 64'h5ca2e27f111a8fc8;

    simon64_96_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .keyIn    (keyIn),
        .busy     (busy),
        .done     (done),
        .keyValid (keyValid),
        .rdAddr   (rdAddr),
`ifdef SIMON_KEYSCHED_REVERSE_EN
        .rdReverse(rdReverse),
`endif
        .rdKey    (rdKey)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] rf(input logic [31:0] x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    task automatic rd(input logic [5:0] a, output logic [31:0] k);
        rdAddr = a;
        #1;
        k = rdKey;
    endtask

    task automatic encrypt(input logic [63:0] pt, output logic [63:0] ct);
        logic [31:0] x, y, t, k;
        x = pt[63:32];
        y = pt[31:0];
        for (int r = 0; r < 42; r++) begin
            rd(6'(r), k);
            t = x;
            x = y ^ rf(x) ^ k;
            y = t;
        end
        ct = {x, y};
    endtask

    task automatic decrypt(input logic [63:0] ct, output logic [63:0] pt);
        logic [31:0] x, y, t, k;
        x = ct[63:32];
        y = ct[31:0];
`ifdef SIMON_KEYSCHED_REVERSE_EN
        rdReverse = 1'b1;
`endif
        for (int r = 0; r < 42; r++) begin
`ifdef SIMON_KEYSCHED_REVERSE_EN
            rd(6'(r), k);
`else
            rd(6'(41 - r), k);
`endif
            t = y;
            y = x ^ rf(y) ^ k;
            x = t;
        end
`ifdef SIMON_KEYSCHED_REVERSE_EN
        rdReverse = 1'b0;
`endif
        pt = {x, y};
    endtask

    // Drives start for one cycle after an edge, then counts edges until done is seen.
    task automatic run_key(input logic [95:0] k, output int edges, output int busy_cyc);
        keyIn    = k;
        start    = 1'b1;
        edges    = 0;
        busy_cyc = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n == 1) start = 1'b0;
            if (busy) busy_cyc++;
            if (done) begin
                edges = n;
                break;
            end
        end
    endtask

    initial begin
        int          edges, bcyc, pulses;
        logic [31:0] k;
        logic [63:0] res;

        rst    = 1'b1;
        start  = 1'b0;
        keyIn  = '0;
        rdAddr = '0;
`ifdef SIMON_KEYSCHED_REVERSE_EN
        rdReverse = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_keyValid", 64'(keyValid), 64'd0);
        rd(6'd0, k);  chk("rst_rd0", 64'(k), 64'd0);
        rd(6'd41, k); chk("rst_rd41", 64'(k), 64'd0);

        // Done appears 40 edges after the edge on which start was driven.
        run_key(K1, edges, bcyc);
        chk("done_latency", 64'(edges), 64'd40);
        chk("busy_cycles", 64'(bcyc), 64'd39);
        chk("keyValid_set", 64'(keyValid), 64'd1);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("keyValid_hold", 64'(keyValid), 64'd1);

        rd(6'd0, k); chk("k1_buf0", 64'(k), 64'h03020100);
        rd(6'd1, k); chk("k1_buf1", 64'(k), 64'h0b0a0908);
        rd(6'd2, k); chk("k1_buf2", 64'(k), 64'h13121110);
        rd(6'd3, k); chk("k1_buf3", 64'(k), 64'hFFAE9DCE);
        encrypt(PT, res); chk("encrypt", res, CT);
        decrypt(CT, res); chk("decrypt", res, PT);
        rd(6'd42, k); chk("rd42_zero", 64'(k), 64'd0);
        rd(6'd63, k); chk("rd63_zero", 64'(k), 64'd0);

        // Accepted start clears keyValid; a second start at i=20 must be ignored.
        keyIn = K1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("keyValid_clr", 64'(keyValid), 64'd0);
        chk("busy_restart", 64'(busy), 64'd1);
        for (int n = 2; n <= 18; n++) tick();
        keyIn  = K2;
        start  = 1'b1;
        pulses = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            start = 1'b0;
            if (done) pulses++;
        end
        chk("one_done_pulse", 64'(pulses), 64'd1);
        rd(6'd0, k); chk("ignored_buf0", 64'(k), 64'h03020100);
        encrypt(PT, res); chk("ignored_encrypt", res, CT);

        // All-zero key exercises the constant path with both z2 polarities.
        run_key(96'd0, edges, bcyc);
        chk("zero_latency", 64'(edges), 64'd40);
        rd(6'd3, k); chk("zero_buf3", 64'(k), 64'hFFFFFFFD);
        rd(6'd4, k); chk("zero_buf4", 64'(k), 64'h9FFFFFFC);

        // Abort at i=25: reset wins and clears the whole buffer.
        tick();
        keyIn = K1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 2; n <= 23; n++) tick();
        chk("busy_before_abort", 64'(busy), 64'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_keyValid", 64'(keyValid), 64'd0);
        pulses = 0;
        for (int a = 0; a < 42; a++) begin
            rd(6'(a), k);
            if (k !== 32'd0) pulses++;
        end
        chk("abort_buf_clear", 64'(pulses), 64'd0);

        run_key(K1, edges, bcyc);
        chk("after_abort_latency", 64'(edges), 64'd40);
        encrypt(PT, res); chk("after_abort_encrypt", res, CT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
